// File: rtl/versa_region_pkg.sv
// Shared constants and FSM state type for the VERSA region table.
package versa_region_pkg;

    // Word offsets inside the register window
    localparam int unsigned OFF_CTRL        = 0;
    localparam int unsigned OFF_STATUS      = 1;
    localparam int unsigned OFF_REGION_BASE = 2;

    // CTRL bit positions
    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_LOCK    = 1;
    localparam int unsigned CTRL_CLR_ERR = 2;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY       = 0;
    localparam int unsigned STAT_LOCKED     = 1;
    localparam int unsigned STAT_ERR        = 2;
    localparam int unsigned STAT_ERR_IDX_LO = 8;

    // Region index width (NREG is at most 16)
    localparam int unsigned IDX_W = 4;

    // Commit sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/versa_region_entry.sv
// One region: shadow min/max with byte writes, active min/max and valid bit.
module versa_region_entry
    import versa_region_pkg::*;
#(
    parameter logic [15:0] RST_MIN = 16'hE07A,
    parameter logic [15:0] RST_MAX = 16'hF000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_min,
    input  logic        wr_max,
    input  logic [1:0]  we,
    input  logic [15:0] din,
    input  logic        load,
    output logic [15:0] shmin,
    output logic [15:0] shmax,
    output logic [15:0] act_min,
    output logic [15:0] act_max,
    output logic        valid,
    output logic        fail_c
);

    logic [15:0] shmin_q, shmin_d;
    logic [15:0] shmax_q, shmax_d;
    logic [15:0] act_min_q, act_min_d;
    logic [15:0] act_max_q, act_max_d;
    logic        valid_q, valid_d;
    logic        pair_ok_c;

    assign pair_ok_c = (shmin_q <= shmax_q);
    assign fail_c    = load & ~pair_ok_c;

    // Byte-lane shadow updates and validated copy into the active pair
    always_comb begin
        shmin_d   = shmin_q;
        shmax_d   = shmax_q;
        act_min_d = act_min_q;
        act_max_d = act_max_q;
        valid_d   = valid_q;
        if (wr_min) begin
            if (we[0]) shmin_d[7:0]  = din[7:0];
            if (we[1]) shmin_d[15:8] = din[15:8];
        end
        if (wr_max) begin
            if (we[0]) shmax_d[7:0]  = din[7:0];
            if (we[1]) shmax_d[15:8] = din[15:8];
        end
        if (load) begin
            if (pair_ok_c) begin
                act_min_d = shmin_q;
                act_max_d = shmax_q;
                valid_d   = 1'b1;
            end else begin
                valid_d   = 1'b0;
            end
        end
    end

    // Region state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shmin_q   <= RST_MIN;
            shmax_q   <= RST_MAX;
            act_min_q <= RST_MIN;
            act_max_q <= RST_MAX;
            valid_q   <= 1'b1;
        end else begin
            shmin_q   <= shmin_d;
            shmax_q   <= shmax_d;
            act_min_q <= act_min_d;
            act_max_q <= act_max_d;
            valid_q   <= valid_d;
        end
    end

    assign shmin   = shmin_q;
    assign shmax   = shmax_q;
    assign act_min = act_min_q;
    assign act_max = act_max_q;
    assign valid   = valid_q;

endmodule

// File: rtl/versa_region_table.sv
// Multi-region VERSA executable-region table with shadow/commit and sticky lock.
module versa_region_table
    import versa_region_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0180,
    parameter int unsigned NREG      = 4,
    parameter int unsigned DEC_WD    = 4,
    parameter logic [15:0] RST_MIN   = 16'hE07A,
    parameter logic [15:0] RST_MAX   = 16'hF000
) (
    input  logic                 mclk,
    input  logic                 puc_rst_n,
    input  logic [13:0]          per_addr,
    input  logic [15:0]          per_din,
    input  logic                 per_en,
    input  logic [1:0]           per_we,
    output logic [15:0]          per_dout,
    output logic [16*NREG-1:0]   er_min,
    output logic [16*NREG-1:0]   er_max,
    output logic [NREG-1:0]      region_valid,
    output logic                 cfg_locked,
    output logic                 commit_busy
);

    fsm_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             busy_q, busy_d;

    logic              reg_sel_c;
    logic [DEC_WD-1:0] offset_c;
    logic              wr_c, rd_c;
    logic              ctrl_wr_c;
    logic              shadow_wr_en_c;
    logic              any_fail_c;

    logic [NREG-1:0]   wr_min_c, wr_max_c, load_c, fail_c;
    logic [15:0]       shmin_w [NREG];
    logic [15:0]       shmax_w [NREG];

    // Address decode
    assign reg_sel_c      = per_en & (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
    assign offset_c       = per_addr[DEC_WD-1:0];
    assign wr_c           = reg_sel_c & (|per_we);
    assign rd_c           = reg_sel_c & ~(|per_we);
    assign ctrl_wr_c      = wr_c & per_we[0] & (offset_c == DEC_WD'(OFF_CTRL));
    assign shadow_wr_en_c = wr_c & ~locked_q & (state_q == ST_IDLE);
    assign any_fail_c     = |fail_c;

    // Region entries
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign wr_min_c[i] = shadow_wr_en_c & (offset_c == DEC_WD'(OFF_REGION_BASE + 2*i));
        assign wr_max_c[i] = shadow_wr_en_c & (offset_c == DEC_WD'(OFF_REGION_BASE + 2*i + 1));
        assign load_c[i]   = (state_q == ST_SCAN) & (idx_q == IDX_W'(i));

        versa_region_entry #(
            .RST_MIN (RST_MIN),
            .RST_MAX (RST_MAX)
        ) u_entry (
            .clk     (mclk),
            .rst_n   (puc_rst_n),
            .wr_min  (wr_min_c[i]),
            .wr_max  (wr_max_c[i]),
            .we      (per_we),
            .din     (per_din),
            .load    (load_c[i]),
            .shmin   (shmin_w[i]),
            .shmax   (shmax_w[i]),
            .act_min (er_min[16*i +: 16]),
            .act_max (er_max[16*i +: 16]),
            .valid   (region_valid[i]),
            .fail_c  (fail_c[i])
        );
    end

    // Commit sequencer, lock and error tracking
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        locked_d  = locked_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        if (ctrl_wr_c && per_din[CTRL_LOCK]) begin
            locked_d = 1'b1;
        end
        if (ctrl_wr_c && per_din[CTRL_CLR_ERR]) begin
            err_d     = 1'b0;
            err_idx_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr_c && per_din[CTRL_COMMIT] && !locked_q) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                // A failure overrides a same-cycle clear; first failure keeps its index
                if (any_fail_c) begin
                    err_d = 1'b1;
                    if (!err_q || (ctrl_wr_c && per_din[CTRL_CLR_ERR])) begin
                        err_idx_d = idx_q;
                    end
                end
                if (idx_q == IDX_W'(NREG - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control state registers
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Same-cycle read mux
    always_comb begin
        per_dout = '0;
        if (rd_c) begin
            if (offset_c == DEC_WD'(OFF_STATUS)) begin
                per_dout[STAT_BUSY]                         = busy_q;
                per_dout[STAT_LOCKED]                       = locked_q;
                per_dout[STAT_ERR]                          = err_q;
                per_dout[STAT_ERR_IDX_LO +: IDX_W]          = err_idx_q;
            end
            for (int i = 0; i < NREG; i++) begin
                if (offset_c == DEC_WD'(OFF_REGION_BASE + 2*i)) per_dout = shmin_w[i];
                if (offset_c == DEC_WD'(OFF_REGION_BASE + 2*i + 1)) per_dout = shmax_w[i];
            end
        end
    end

    assign cfg_locked  = locked_q;
    assign commit_busy = busy_q;

endmodule

// File: doc/versa_region_table.md
Name: versa_region_table

Overview:
- Parametrised successor to the single-region VERSA ER_min/ER_max metadata peripheral.
- Holds NREG executable regions, each with a 16-bit min and a 16-bit max.
- Software writes shadow copies over the openMSP430 peripheral bus, then triggers a commit. A sequencer validates each region (min <= max) and copies it into the active copy, one region per cycle.
- A sticky LOCK freezes the table until reset. The active outputs feed the VERSA/VRASED monitor logic.

Parameters:
- BASE_ADDR, 15'h0180: byte base address; must be aligned to 2^(DEC_WD+1) bytes.
- NREG, 4: number of regions, 1..16.
- DEC_WD, 4: word-decoder width; 2^DEC_WD must be >= 2+2*NREG.
- RST_MIN, 16'hE07A: reset value of every shadow and active min.
- RST_MAX, 16'hF000: reset value of every shadow and active max.

Ports:
- mclk  in  1  main system clock
- puc_rst_n  in  1  synchronous active-low reset
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables ([0] = low byte, [1] = high byte)
- per_dout  out  16  read data (combinational, same cycle)
- er_min  out  16*NREG  active mins; region i occupies [16i+15:16i]
- er_max  out  16*NREG  active maxes, same packing
- region_valid  out  NREG  active region i holds a validated pair
- cfg_locked  out  1  table locked
- commit_busy  out  1  sequencer running

Behaviour:
- Clock and reset: one clock, mclk. Reset is synchronous and active-low (puc_rst_n), sampled on the mclk rising edge.
- Register decode:
  - reg_sel = per_en & (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]).
  - offset = per_addr[DEC_WD-1:0].
  - Write = reg_sel & |per_we. Read = reg_sel & ~|per_we.
- Word map:
  - 0 CTRL (write-only, reads 0): bit0 COMMIT, bit1 LOCK, bit2 CLR_ERR; each acts when written 1.
  - 1 STATUS (read-only): bit0 busy, bit1 locked, bit2 err, bits[11:8] err_idx, all other bits 0.
  - 2+2i SHMIN[i]; 3+2i SHMAX[i], read/write.
  - Offsets >= 2+2*NREG read 0; writes to them are ignored.
- Byte writes: per_we[0] updates bits [7:0]; per_we[1] updates bits [15:8]. CTRL acts on per_we[0] only.
- Reset values:
  - Shadow and active registers = RST_MIN/RST_MAX.
  - region_valid = all ones.
  - cfg_locked, commit_busy, err, err_idx = 0.
  - FSM = IDLE.
  - per_dout = 0 when no read is selected.
- Locking:
  - LOCK is sticky until reset.
  - While locked, shadow writes and COMMIT are ignored; CLR_ERR still works.
  - LOCK written while busy: lock takes effect next cycle; the running commit completes.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on an accepted COMMIT write: not locked, not busy. Index idx is cleared to 0.
  - SCAN: one region per cycle.
    - If shmin[idx] <= shmax[idx] (unsigned): copy both to active and set region_valid[idx].
    - Otherwise: active stays unchanged, region_valid[idx] is cleared, err is set. err_idx is written only if err was 0 beforehand, so it records the first failure.
    - idx == NREG-1 -> DONE; else idx+1.
  - DONE -> IDLE after one cycle.
- Timing: a COMMIT write in cycle 0 makes commit_busy = 1 during cycles 1..NREG+1. Region i's active values change at the end of cycle 1+i.
- Conflicts while busy:
  - Shadow writes are ignored, so the commit is atomic against its snapshot.
  - A second COMMIT is ignored.
  - CLR_ERR and a failure in the same cycle: the failure wins.
- Reset mid-SCAN: all state returns to reset values. Already-committed regions are lost.
- Equal min and max is a valid region.

Decomposition:
- Package versa_region_pkg holds:
  - the offset constants (CTRL = 0, STATUS = 1, REGION_BASE = 2);
  - the CTRL/STATUS bit indices;
  - the FSM state enum (IDLE, SCAN, DONE).
- Sub-module versa_region_entry: one region's shadow pair, active pair, valid bit and byte-write logic, instantiated NREG times. Decode, CTRL/STATUS and the FSM stay at top level.

Test Plan:
- Reset -> er_min region i = 16'hE07A, er_max region i = 16'hF000 for all i; region_valid = 4'b1111; STATUS reads 0.
- Write SHMIN[1] = 16'hC000, SHMAX[1] = 16'hC0FF, then COMMIT -> commit_busy for 5 cycles. Region 1 active updates at the end of cycle 2. Other regions are unchanged. region_valid = 4'b1111.
- Write SHMIN[2] = 16'h9000, SHMAX[2] = 16'h8000, then COMMIT -> region 2 active stays E07A/F000; region_valid[2] = 0; STATUS = 16'h0204. CLR_ERR then gives STATUS = 0.
- Byte write: per_we = 2'b10 with din 16'hAB00 to SHMIN[0] (value 16'hE07A) -> reads back 16'hAB7A.
- LOCK, then SHMAX[0] write and COMMIT -> shadow, active and busy are unchanged; STATUS bit1 = 1 until puc_rst_n pulses low.
- COMMIT, then SHMIN[3] write in cycle 2 plus a reset pulse in cycle 3 -> SHMIN[3] write is ignored; after reset all values are back to defaults and busy = 0.
